// File: rtl/tap_readback_if.sv
// Downstream tap-word stream between tap_readback (master) and its consumer (slave).
interface tap_readback_if #(
    parameter int DW = 32
);
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;

    modport master (output o_data, output o_valid, output o_last, input i_ready);
    modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/tap_readback.sv
// Reads FIR taps 0..NTAPS-1 from the tap RAM and streams them out one per handshake.
// Optional TAP_READBACK_CONVERT_EN: convert each IEEE-754 single tap to a saturated int32.
module tap_readback #(
    parameter int NTAPS  = 103,
    parameter int IW     = 9,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic            i_start,
    output logic            o_rd_en,
    output logic [IW-1:0]   o_rd_idx,
    input  logic [DW-1:0]   i_rd_data,
    tap_readback_if.master  stream,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [2:0]    LAT_LAST = 3'(RD_LAT - 1);

    logic [2:0]    state;
    logic [IW-1:0] index;
    logic [2:0]    lat_cnt;
    logic [DW-1:0] data_q;
    logic [DW-1:0] cap_data;

`ifdef TAP_READBACK_CONVERT_EN
    // Float to int32, truncating toward zero; NaN and overflow saturate.
    function automatic logic signed [31:0] f2i_sat(input logic [31:0] f);
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] man;
        logic [7:0]  sh;
        logic [31:0] mag;
        begin
            sign = f[31];
            expo = f[30:23];
            man  = f[22:0];
            sh   = expo - 8'd127;
            mag  = {8'd0, 1'b1, man};
            if (expo == 8'hFF && man != 23'd0) begin
                f2i_sat = 32'sh7FFF_FFFF;
            end else if (expo < 8'd127) begin
                f2i_sat = 32'sd0;
            end else if (expo >= 8'd158) begin
                f2i_sat = sign ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
            end else begin
                if (sh >= 8'd23) mag = mag << (sh - 8'd23);
                else             mag = mag >> (8'd23 - sh);
                f2i_sat = sign ? $signed(~mag + 32'd1) : $signed(mag);
            end
        end
    endfunction

    always_comb begin
        cap_data = DW'(f2i_sat(i_rd_data[31:0]));
    end
`else
    always_comb begin
        cap_data = i_rd_data;
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            index   <= '0;
            lat_cnt <= '0;
            data_q  <= '0;
        end else if (i_ce) begin
            case (state)
                S_IDLE: begin
                    if (!i_start) begin
                        index <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= '0;
                    state   <= S_WAIT;
                end
                // Capture on the last latency cycle so o_data appears with o_valid.
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        data_q <= cap_data;
                        state  <= S_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (stream.i_ready) begin
                        if (index == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            index <= index + IW'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The strobe is gated by i_ce so a frozen ISSUE cycle never repeats the read.
    assign o_rd_en        = (state == S_ISSUE) && i_ce;
    assign o_rd_idx       = index;
    assign stream.o_data  = data_q;
    assign stream.o_valid = (state == S_HOLD);
    assign stream.o_last  = (state == S_HOLD) && (index == LAST_IDX);
    assign o_busy         = (state == S_ISSUE) || (state == S_WAIT) || (state == S_HOLD);
    assign o_done         = (state == S_DONE);

endmodule

// File: tb/tb_tap_readback.sv
// Directed bench for tap_readback with a one-cycle-latency tap RAM model.
module tb_tap_readback;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        start;
    logic        rd_en;
    logic [8:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] mem [0:102];

    int checks = 0;
    int errors = 0;

    tap_readback_if #(.DW(32)) sif ();

    tap_readback dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_ce      (ce),
        .i_start   (start),
        .o_rd_en   (rd_en),
        .o_rd_idx  (rd_idx),
        .i_rd_data (rd_data),
        .stream    (sif),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_idx];
    end

    function automatic logic [31:0] exp_word(input int k);
`ifdef TAP_READBACK_CONVERT_EN
        // 1.0 plus a few ulps truncates to 1.
        return 32'd1;
`else
        return 32'h3F80_0000 + 32'(k);
`endif
    endfunction

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_hold(input int k, output bit ok);
        int seen = 0;
        ok = 1'b0;
        sif.i_ready = 1'b1;
        start = 1'b0;
        tick();
        start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (sif.o_valid) begin
                if (seen == k) begin
                    ok = 1'b1;
                    return;
                end
                seen++;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        sif.i_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic finish_run(input string tag);
        bit ok;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout got done=%b want 1", tag, done);
        end
        start = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; start = 1'b1; sif.i_ready = 1'b0; rd_data = '0;
        #3;
        checks++;
        if ({rd_en, rd_idx, sif.o_data, sif.o_valid, sif.o_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b idx=%0d data=%h v=%b l=%b b=%b d=%b want all 0",
                     rd_en, rd_idx, sif.o_data, sif.o_valid, sif.o_last, busy, done);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_raw_readback();
        int xfers = 0;
        sif.i_ready = 1'b1;
        start = 1'b0;
        tick();
        start = 1'b1;
        checks++;
        if (rd_en !== 1'b1 || rd_idx !== 9'd0 || sif.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL raw_first_issue got en=%b idx=%0d v=%b want 1 0 0", rd_en, rd_idx, sif.o_valid);
        end
        tick();
        tick();
        for (int k = 0; k < 103; k++) begin
            checks++;
            if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(k)) begin
                errors++;
                $display("FAIL raw_data k=%0d got v=%b data=%h want v=1 data=%h", k, sif.o_valid, sif.o_data, exp_word(k));
            end
            checks++;
            if (sif.o_last !== (k == 102)) begin
                errors++;
                $display("FAIL raw_last k=%0d got %b want %b", k, sif.o_last, (k == 102));
            end
            if (sif.o_valid === 1'b1) xfers++;
            tick();
            if (k < 102) begin
                checks++;
                if (rd_en !== 1'b1 || rd_idx !== 9'(k + 1) || sif.o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL raw_issue k=%0d got en=%b idx=%0d v=%b want 1 %0d 0", k + 1, rd_en, rd_idx, sif.o_valid, k + 1);
                end
                tick();
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || sif.o_valid !== 1'b0 || sif.o_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL raw_done got d=%b v=%b l=%b b=%b want 1 0 0 0", done, sif.o_valid, sif.o_last, busy);
        end
        checks++;
        if (xfers !== 103) begin
            errors++;
            $display("FAIL raw_xfer_count got %0d want 103", xfers);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL raw_back_idle got done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        run_to_hold(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_reach_tap10 got timeout want tap 10 valid");
        end
        sif.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(10) || rd_en !== 1'b0 || rd_idx !== 9'd10) begin
                errors++;
                $display("FAIL bp_stall i=%0d got v=%b data=%h en=%b idx=%0d want 1 %h 0 10",
                         i, sif.o_valid, sif.o_data, rd_en, rd_idx, exp_word(10));
            end
        end
        sif.i_ready = 1'b1;
        tick();
        checks++;
        if (rd_en !== 1'b1 || rd_idx !== 9'd11) begin
            errors++;
            $display("FAIL bp_resume got en=%b idx=%0d want 1 11", rd_en, rd_idx);
        end
        finish_run("bp");
    endtask

    task automatic test_start_held();
        bit ok;
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL held_done_timeout got done=%b want 1", done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL held_no_retrigger i=%0d got d=%b b=%b en=%b want 1 0 0", i, done, busy, rd_en);
            end
        end
        start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_release got d=%b b=%b want 0 0", done, busy);
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        checks++;
        if (rd_en !== 1'b1 || rd_idx !== 9'd0) begin
            errors++;
            $display("FAIL held_restart got en=%b idx=%0d want 1 0", rd_en, rd_idx);
        end
        finish_run("held");
    endtask

    task automatic test_reset_midrun();
        bit ok;
        run_to_hold(50, ok);
        checks++;
        if (!ok || sif.o_data !== exp_word(50)) begin
            errors++;
            $display("FAIL rstmid_reach got ok=%b data=%h want 1 %h", ok, sif.o_data, exp_word(50));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rd_en, rd_idx, sif.o_data, sif.o_valid, sif.o_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got en=%b idx=%0d data=%h v=%b l=%b b=%b d=%b want all 0",
                     rd_en, rd_idx, sif.o_data, sif.o_valid, sif.o_last, busy, done);
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        checks++;
        if (rd_en !== 1'b1 || rd_idx !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_restart got en=%b idx=%0d want 1 0", rd_en, rd_idx);
        end
        tick();
        tick();
        checks++;
        if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(0)) begin
            errors++;
            $display("FAIL rstmid_first got v=%b data=%h want 1 %h", sif.o_valid, sif.o_data, exp_word(0));
        end
        finish_run("rstmid");
    endtask

    task automatic test_clock_enable();
        bit ok;
        run_to_hold(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ce_reach_tap20 got timeout want tap 20 valid");
        end
        tick();
        tick();
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sif.o_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ce_wait_freeze i=%0d got v=%b en=%b b=%b want 0 0 1", i, sif.o_valid, rd_en, busy);
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(21)) begin
            errors++;
            $display("FAIL ce_wait_resume got v=%b data=%h want 1 %h", sif.o_valid, sif.o_data, exp_word(21));
        end
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(21) || rd_en !== 1'b0 || rd_idx !== 9'd21) begin
                errors++;
                $display("FAIL ce_hold_freeze i=%0d got v=%b data=%h en=%b idx=%0d want 1 %h 0 21",
                         i, sif.o_valid, sif.o_data, rd_en, rd_idx, exp_word(21));
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (rd_en !== 1'b1 || rd_idx !== 9'd22) begin
            errors++;
            $display("FAIL ce_hold_resume got en=%b idx=%0d want 1 22", rd_en, rd_idx);
        end
        tick();
        tick();
        checks++;
        if (sif.o_valid !== 1'b1 || sif.o_data !== exp_word(22)) begin
            errors++;
            $display("FAIL ce_next_tap got v=%b data=%h want 1 %h", sif.o_valid, sif.o_data, exp_word(22));
        end
        finish_run("ce");
    endtask

`ifdef TAP_READBACK_CONVERT_EN
    task automatic test_convert();
        logic [31:0] vin  [0:4];
        logic [31:0] vexp [0:4];
        vin[0] = 32'h3F80_0000; vexp[0] = 32'h0000_0001;
        vin[1] = 32'hC049_0FDB; vexp[1] = 32'hFFFF_FFFD;
        vin[2] = 32'h3F00_0000; vexp[2] = 32'h0000_0000;
        vin[3] = 32'h4F80_0000; vexp[3] = 32'h7FFF_FFFF;
        vin[4] = 32'h7FC0_0000; vexp[4] = 32'h7FFF_FFFF;
        for (int k = 0; k < 5; k++) mem[k] = vin[k];
        sif.i_ready = 1'b1;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (sif.o_valid !== 1'b1 || sif.o_data !== vexp[k]) begin
                errors++;
                $display("FAIL conv k=%0d in=%h got v=%b data=%h want 1 %h", k, vin[k], sif.o_valid, sif.o_data, vexp[k]);
            end
            tick();
            tick();
            tick();
        end
        finish_run("conv");
        for (int k = 0; k < 5; k++) mem[k] = 32'h3F80_0000 + 32'(k);
    endtask
`endif

    initial begin
        for (int k = 0; k < 103; k++) mem[k] = 32'h3F80_0000 + 32'(k);
        test_reset();
        test_raw_readback();
        test_backpressure();
        test_start_held();
        test_reset_midrun();
        test_clock_enable();
`ifdef TAP_READBACK_CONVERT_EN
        test_convert();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_readback.md
# tap_readback

Reads the FIR coefficient memory back out, one tap per transfer, over a valid/ready stream. It is the read-side counterpart of the tap-loading controller: that block writes taps 0..102 in order on an active-low start, and this block reads them back in the same order, on the same active-low start convention, for checking and debug capture. It sits between the tap RAM's read port and any downstream consumer, such as a UART packer or a test capture FIFO.

## Interface
- NTAPS, 103: number of taps read per run (indices 0..NTAPS-1).
- IW, 9: index width; must satisfy 2^IW >= NTAPS.
- DW, 32: tap word width (IEEE-754 single when conversion is enabled).
- RD_LAT, 1: tap RAM read latency in cycles, from o_rd_en to valid i_rd_data; legal range 1..4.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ce  in  1  clock enable; 0 freezes the FSM, counters and all registered outputs.
- i_start  in  1  active-low run request (level).
- o_rd_en  out  1  one-cycle RAM read strobe.
- o_rd_idx  out  IW  RAM read address.
- i_rd_data  in  DW  RAM read data.
- o_data  out  DW  tap word presented downstream.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_last  out  1  high with o_valid on tap NTAPS-1.
- o_busy  out  1  high in ISSUE, WAIT and HOLD.
- o_done  out  1  high in DONE.

## Operation
- States:
  - IDLE → ISSUE when i_start==0. The index is set to 0 on entry to ISSUE.
  - ISSUE: o_rd_en=1 and o_rd_idx=index, for exactly one cycle. → WAIT.
  - WAIT: count RD_LAT cycles. On the last one, register i_rd_data (after optional conversion) into o_data. → HOLD.
  - HOLD: o_valid=1, and o_data is stable until accepted.
    - On o_valid&&i_ready: if index==NTAPS-1 → DONE; else index+1 → ISSUE.
  - DONE: o_done=1. → IDLE only when i_start==1. A held-low start does not retrigger a run.
- i_start is sampled only in IDLE and DONE. Releasing it mid-run has no effect; the run completes.
- i_ce==0 blocks every transition and the handshake. A transfer counts only on a cycle where i_ce, o_valid and i_ready are all 1.
- o_rd_idx holds its last value outside ISSUE. o_data holds the last accepted word outside HOLD.
- Async reset in any state:
  - returns to IDLE immediately;
  - index=0, o_data=0;
  - all outputs 0.
  - Any partial run is abandoned; a new run always restarts at tap 0.

## Timing
- Reset values: o_rd_en=0, o_rd_idx=0, o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0.
- Start to first o_valid: 1 cycle (IDLE→ISSUE) + 1 cycle (ISSUE) + RD_LAT cycles. With RD_LAT=1 this is o_valid in cycle 3 after the start is sampled.
- Per-tap period with i_ready held at 1: RD_LAT+2 cycles. A full run at the defaults takes 103×3 = 309 cycles, plus entry.
- The accepting edge on the last tap moves to DONE. o_done rises the next cycle, and o_valid and o_last fall in the same cycle.
- Index arithmetic is unsigned IW bits. The index never exceeds NTAPS-1, so there is no wrap.

## Configuration
- TAP_READBACK_CONVERT_EN defined:
  - i_rd_data is treated as IEEE-754 single and converted to signed 32-bit integer, truncating toward zero, in the capture cycle. Latency is unchanged.
  - Exponent < 127 gives 0.
  - Magnitudes ≥ 2^31 saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative).
  - NaN gives 0x7FFFFFFF.
- Not defined: o_data is the raw i_rd_data bits.

## Test plan
- Raw readback: RAM tap k = 0x3F800000+k, i_ready=1, i_start low for 1 cycle.
  - Expect 103 transfers in order, 0x3F800000..0x3F800066, each RD_LAT+2 cycles apart.
  - o_last only on 0x3F800066; o_done 1 the next cycle.
- Backpressure: i_ready=0 for 5 cycles on tap 10.
  - o_valid stays 1 and o_data stays constant.
  - No read for tap 11 is issued until the accepting edge.
- Start held low through DONE: the FSM stays in DONE with no second run. Release start, low again: the run restarts at index 0.
- Reset mid-run at tap 50, during HOLD:
  - next cycle all outputs are 0;
  - the next start reads tap 0 first.
- i_ce=0 for 4 cycles during WAIT and during HOLD with i_ready=1: no state change and no transfer counted. The sequence resumes intact.
- With TAP_READBACK_CONVERT_EN, taps 0x3F800000, 0xC0490FDB, 0x3F000000, 0x4F800000, 0x7FC00000 must read back as 1, -3, 0, 0x7FFFFFFF and 0x7FFFFFFF.
